fp_addsub: RTL
==============

# fp_addsub

Pipelined IEEE-754 binary floating-point adder/subtractor with per-operation add/sub select, valid/ready flow control in both directions and implemented overflow/underflow/invalid flags. It sits in the FPU datapath beside the multiplier and divider and is the replacement for the fixed-latency adder, which had no backpressure and no status flags. Format is parametrised by total width and exponent width. Rounding is round-to-nearest-even, and subnormal inputs and outputs are flushed to zero.

## Interface
- DATA_W, 32, total word width
- EXP_W, 8, exponent width; FRAC_W = DATA_W-EXP_W-1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- op_a  in  DATA_W  operand A
- op_b  in  DATA_W  operand B
- sub  in  1  1: A-B, 0: A+B (sampled with operands)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res  out  DATA_W  result
- overflow  out  1  result rounded beyond max finite (qualified by out_valid)
- underflow  out  1  nonzero result flushed to zero
- invalid  out  1  NaN produced from non-NaN operands or NaN operand

## Operation
- Effective B sign = op_b sign XOR sub. Operands swapped so A has the larger magnitude (exponent, then fraction).
- Exponent field 0 → operand is ±0 (hidden bit 0, flush-to-zero).
- Alignment: smaller significand right-shifted by the exponent difference into a FRAC_W+1+3 bit field (guard, round, sticky). Differences ≥ FRAC_W+4 saturate, and all bits go to sticky.
- Add or subtract the significands (effective op = sign XOR). The sum carries one extra bit.
- Normalise: on carry, shift right 1 (OR the LSB into sticky) and add 1 to the exponent. Otherwise, shift left by the leading-zero count and subtract it from the exponent.
- RNE on guard/round/sticky. If rounding carries out of the significand, increment the exponent.
- Exact cancellation gives +0. Both operands −0 gives −0.
- Biased exponent after rounding ≥ 2^EXP_W−1 → ±Inf, overflow=1.
- Normalised exponent ≤ 0 → ±0, underflow=1.
- Flags are zero whenever they do not apply. Flags travel with their result.

## Timing
- 4-stage pipeline: S1 unpack/swap/align, S2 add, S3 normalise, S4 round/pack into output registers.
- Latency: operands accepted at edge N produce out_valid=1 after edge N+4 when there is no stall.
- Throughput: 1 op/cycle.
- Handshake: transfer occurs when valid && ready.
  - Pipeline advance enable is en = ~out_valid | out_ready.
  - in_ready = en. This is a global stall; bubbles are not compressed.
  - in_ready may depend combinationally on out_ready.
- While out_valid=1 and out_ready=0, res and all flags hold stable.
- Results emerge in acceptance order. No result is dropped or duplicated.
- Reset: all stage valids, out_valid, res, overflow, underflow and invalid are 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards in-flight ops.
- Simultaneous in_valid, out_valid and out_ready: accept and emit in the same cycle.

## Configuration
- FP_SPECIAL_EN defined:
  - Exponent all-ones is decoded as Inf/NaN.
  - Any NaN operand → canonical NaN (0x7FC00000 pattern generalised: sign 0, exp all-ones, fraction MSB 1), invalid=1.
  - Inf−Inf (effective) → canonical NaN, invalid=1.
  - Inf±finite → that Inf. Same-sign Inf+Inf → Inf.
  - Special results use the same 4-cycle pipeline slot, so ordering is preserved.
- Not defined:
  - All-ones exponents are treated as ordinary finite values.
  - invalid tied to 0.
  - overflow/underflow still implemented.

## Structure
- fp_defs.vh holds: FRAC_W/BIAS derivations, canonical NaN, the INF(sign) macro and the GRS width (3).
- Sub-module: the existing clz leading-zero counter, instantiated in S3 with width FRAC_W+4.
- Everything else is inline. Each stage register carries its valid bit, sign, exponent and the flags known so far.

## Test plan
- 0x3F800000 + 0x40000000, sub=0 → res 0x40400000, flags 0, out_valid exactly 4 cycles after accept.
- 0x3F800000 − 0x3F800000 (sub=1) → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000.
- RNE:
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even).
  - 0x3F800000 + 0x34400000 → 0x3F800002.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1. 0x00800000 − 0x00800001 → 0x80000000, underflow=1.
- Backpressure: stream 8 random ops back-to-back, hold out_ready=0 for cycles 3–6 and toggle it randomly afterwards → all 8 results correct and in order, res stable while stalled, in_ready=0 while stalled with out_valid=1.
- FP_SPECIAL_EN:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7F800000 + 0x3F800000 → 0x7F800000.
  - rst asserted with 3 ops in flight → out_valid=0 next cycle and no stale results afterwards.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_pkg
// Description : Shared definitions for the fp_addsub floating-point adder.
//               Holds the guard/round/sticky width and helpers that derive
//               the fraction width and exponent bias from a format.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_addsub_pkg;

    // Guard, round and sticky bits appended below the significand.
    localparam int GRS_W = 3;

    function automatic int calc_frac_w(input int data_w, input int exp_w);
        return data_w - exp_w - 1;
    endfunction

    function automatic int calc_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_clz.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_clz
// Description : Combinational leading-zero counter. An all-zero input
//               returns WIDTH.
// Ports       : i_data  [WIDTH-1:0]  value to scan (MSB first)
//               o_count [CNT_W-1:0]  number of leading zeros
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_clz #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub
// Description : Pipelined IEEE-754 adder/subtractor, round-to-nearest-even,
//               subnormals flushed to zero, valid/ready flow control with a
//               global stall. Operands accepted at edge N give a result
//               after edge N+4.
//               Build option FP_SPECIAL_EN: decode Inf/NaN operands.
// Ports       : clk, rst                  clock, sync active-high reset
//               in_valid/in_ready         operand handshake
//               op_a, op_b, sub           operands, 1 = A-B
//               out_valid/out_ready       result handshake
//               res, overflow, underflow, invalid   result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub
    import fp_addsub_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res,
    output logic              overflow,
    output logic              underflow,
    output logic              invalid
);

    localparam int C_FRAC_W = calc_frac_w(DATA_W, EXP_W);
    localparam int C_SIG_W  = C_FRAC_W + 1;
    localparam int C_ALN_W  = C_SIG_W + GRS_W;
    localparam int C_SUM_W  = C_ALN_W + 1;
    localparam int C_LZC_W  = $clog2(C_ALN_W + 1);
    localparam int C_XW     = EXP_W + 2;   // signed working exponent
    localparam logic [EXP_W-1:0]        C_EXP_MAX = '1;
    localparam logic signed [C_XW-1:0]  C_EXP_OVF = C_XW'((1 << EXP_W) - 1);

    function automatic logic [DATA_W-1:0] f_inf(input logic s);
        f_inf = {s, C_EXP_MAX, {C_FRAC_W{1'b0}}};
    endfunction

    logic w_en;
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    // ---------------- input capture ----------------
    logic              r0_valid, r0_sub;
    logic [DATA_W-1:0] r0_a, r0_b;

    // ---------------- S1: unpack / swap / align ----------------
    logic                w_sa, w_sb, w_za, w_zb, w_swap, w_sbig, w_zbig, w_zsml;
    logic [EXP_W-1:0]    w_ea, w_eb, w_ebig, w_esml, w_diff;
    logic [C_FRAC_W-1:0] w_fa, w_fb, w_fbig, w_fsml;
    logic [C_ALN_W-1:0]  w_sig_big, w_sig_sml, w_aln;
    logic                w_stk, w_zsgn, w_spc, w_inv;
    logic [DATA_W-1:0]   w_spc_res;

    always_comb begin
        w_sa   = r0_a[DATA_W-1];
        w_sb   = r0_b[DATA_W-1] ^ r0_sub;
        w_ea   = r0_a[DATA_W-2:C_FRAC_W];
        w_eb   = r0_b[DATA_W-2:C_FRAC_W];
        w_za   = (w_ea == '0);
        w_zb   = (w_eb == '0);
        // Subnormal fractions are dropped before the magnitude compare.
        w_fa   = w_za ? '0 : r0_a[C_FRAC_W-1:0];
        w_fb   = w_zb ? '0 : r0_b[C_FRAC_W-1:0];
        w_swap = {w_eb, w_fb} > {w_ea, w_fa};
        w_sbig = w_swap ? w_sb : w_sa;
        w_ebig = w_swap ? w_eb : w_ea;
        w_esml = w_swap ? w_ea : w_eb;
        w_fbig = w_swap ? w_fb : w_fa;
        w_fsml = w_swap ? w_fa : w_fb;
        w_zbig = w_swap ? w_zb : w_za;
        w_zsml = w_swap ? w_za : w_zb;
        w_sig_big = {~w_zbig, w_fbig, {GRS_W{1'b0}}};
        w_sig_sml = {~w_zsml, w_fsml, {GRS_W{1'b0}}};
        w_diff    = w_ebig - w_esml;
        if (32'(w_diff) >= 32'(C_ALN_W)) begin
            w_aln = '0;
            w_stk = |w_sig_sml;
        end else begin
            w_aln = w_sig_sml >> w_diff;
            w_stk = |(w_sig_sml & ~({C_ALN_W{1'b1}} << w_diff));
        end
        w_aln[0] = w_aln[0] | w_stk;
        // Only -0 + -0 (after the sub inversion) keeps a negative zero.
        w_zsgn = w_za & w_zb & w_sa & w_sb;
    end

`ifdef FP_SPECIAL_EN
    localparam logic [DATA_W-1:0] C_QNAN = {1'b0, C_EXP_MAX, 1'b1, {(C_FRAC_W-1){1'b0}}};
    logic w_na, w_nb, w_ia, w_ib;
    always_comb begin
        w_na = (w_ea == C_EXP_MAX) && (r0_a[C_FRAC_W-1:0] != '0);
        w_nb = (w_eb == C_EXP_MAX) && (r0_b[C_FRAC_W-1:0] != '0);
        w_ia = (w_ea == C_EXP_MAX) && (r0_a[C_FRAC_W-1:0] == '0);
        w_ib = (w_eb == C_EXP_MAX) && (r0_b[C_FRAC_W-1:0] == '0);
        w_spc = w_na | w_nb | w_ia | w_ib;
        w_inv = w_na | w_nb | (w_ia & w_ib & (w_sa != w_sb));
        if (w_inv)     w_spc_res = C_QNAN;
        else if (w_ia) w_spc_res = f_inf(w_sa);
        else           w_spc_res = f_inf(w_sb);
    end
`else
    assign w_spc     = 1'b0;
    assign w_inv     = 1'b0;
    assign w_spc_res = '0;
`endif

    logic               r1_valid, r1_sign, r1_esub, r1_zsgn, r1_spc, r1_inv;
    logic [EXP_W-1:0]   r1_exp;
    logic [C_ALN_W-1:0] r1_big, r1_sml;
    logic [DATA_W-1:0]  r1_spc_res;

    // ---------------- S2: add / subtract ----------------
    logic [C_SUM_W-1:0] w_sum;
    // The swap guarantees big >= small, so the difference never goes negative.
    assign w_sum = r1_esub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                           : ({1'b0, r1_big} + {1'b0, r1_sml});

    logic               r2_valid, r2_sign, r2_zsgn, r2_spc, r2_inv;
    logic [EXP_W-1:0]   r2_exp;
    logic [C_SUM_W-1:0] r2_sum;
    logic [DATA_W-1:0]  r2_spc_res;

    // ---------------- S3: normalise ----------------
    logic [C_LZC_W-1:0]     w_lz;
    logic [C_ALN_W-1:0]     w_nsig;
    logic signed [C_XW-1:0] w_nexp;
    logic                   w_zero, w_uf;

    fp_addsub_clz #(
        .WIDTH (C_ALN_W),
        .CNT_W (C_LZC_W)
    ) u_clz (
        .i_data  (r2_sum[C_ALN_W-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        if (r2_sum[C_SUM_W-1]) begin
            w_nsig = {r2_sum[C_SUM_W-1:2], r2_sum[1] | r2_sum[0]};
            w_nexp = $signed({2'b00, r2_exp}) + C_XW'(1);
        end else begin
            w_nsig = r2_sum[C_ALN_W-1:0] << w_lz;
            w_nexp = $signed({2'b00, r2_exp}) - $signed({{(C_XW-C_LZC_W){1'b0}}, w_lz});
        end
        w_zero = ~r2_sum[C_SUM_W-1] && (32'(w_lz) == 32'(C_ALN_W));
        w_uf   = ~w_zero && (w_nexp <= 0);
    end

    logic                   r3_valid, r3_sign, r3_zero, r3_uf, r3_spc, r3_inv;
    logic signed [C_XW-1:0] r3_exp;
    logic [C_ALN_W-1:0]     r3_sig;
    logic [DATA_W-1:0]      r3_spc_res;

    // ---------------- S4: round / pack ----------------
    logic [C_SIG_W-1:0]     w_mant;
    logic [C_SIG_W:0]       w_mr;
    logic                   w_rup, w_rzero, w_ovf;
    logic signed [C_XW-1:0] w_rexp;
    logic [C_FRAC_W-1:0]    w_frac;
    logic [DATA_W-1:0]      w_res;
    logic                   w_res_ov, w_res_uf, w_res_inv;

    always_comb begin
        w_mant  = r3_sig[C_ALN_W-1:GRS_W];
        // Round up above half, or on an exact half when the LSB is odd.
        w_rup   = r3_sig[2] & (r3_sig[1] | r3_sig[0] | w_mant[0]);
        w_mr    = {1'b0, w_mant} + (C_SIG_W+1)'(w_rup);
        w_rexp  = r3_exp + $signed({{(C_XW-1){1'b0}}, w_mr[C_SIG_W]});
        w_frac  = w_mr[C_SIG_W] ? '0 : w_mr[C_FRAC_W-1:0];
        w_rzero = r3_zero | ~(w_mr[C_SIG_W] | w_mr[C_FRAC_W]);
        w_ovf   = ~w_rzero && (w_rexp >= C_EXP_OVF);
        w_res     = {r3_sign, w_rexp[EXP_W-1:0], w_frac};
        w_res_ov  = 1'b0;
        w_res_uf  = 1'b0;
        w_res_inv = 1'b0;
        if (r3_spc) begin
            w_res     = r3_spc_res;
            w_res_inv = r3_inv;
        end else if (w_rzero) begin
            w_res    = {r3_sign, {(DATA_W-1){1'b0}}};
            w_res_uf = r3_uf;
        end else if (w_ovf) begin
            w_res    = f_inf(r3_sign);
            w_res_ov = 1'b1;
        end
    end

    // ---------------- control: valids and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid  <= 1'b0;
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (w_en) begin
            r0_valid  <= in_valid;
            r1_valid  <= r0_valid;
            r2_valid  <= r1_valid;
            r3_valid  <= r2_valid;
            out_valid <= r3_valid;
            res       <= w_res;
            overflow  <= w_res_ov;
            underflow <= w_res_uf;
            invalid   <= w_res_inv;
        end
    end

    // ---------------- datapath stage registers ----------------
    always_ff @(posedge clk) begin
        if (w_en) begin
            r0_a       <= op_a;
            r0_b       <= op_b;
            r0_sub     <= sub;
            r1_sign    <= w_sbig;
            r1_exp     <= w_ebig;
            r1_big     <= w_sig_big;
            r1_sml     <= w_aln;
            r1_esub    <= w_sa ^ w_sb;
            r1_zsgn    <= w_zsgn;
            r1_spc     <= w_spc;
            r1_inv     <= w_inv;
            r1_spc_res <= w_spc_res;
            r2_sign    <= r1_sign;
            r2_exp     <= r1_exp;
            r2_sum     <= w_sum;
            r2_zsgn    <= r1_zsgn;
            r2_spc     <= r1_spc;
            r2_inv     <= r1_inv;
            r2_spc_res <= r1_spc_res;
            r3_sign    <= w_zero ? r2_zsgn : r2_sign;
            r3_exp     <= w_nexp;
            r3_sig     <= w_nsig;
            r3_zero    <= w_zero | w_uf;
            r3_uf      <= w_uf;
            r3_spc     <= r2_spc;
            r3_inv     <= r2_inv;
            r3_spc_res <= r2_spc_res;
        end
    end

endmodule
`default_nettype wire
